// File: rtl/pipe_stall_ctrl.sv
// Purpose : central stall/flush controller for the five-stage pipeline; defers flushes
//           behind outstanding memory accesses, watchdogs long memory waits into a
//           bus-error flush and counts stalled cycles.
// Latency : stall is combinational from the requests (0 cycles); flush/new_pc/bus_err
//           are registered (flush one cycle after an accepted request).
// Backpressure: stallreq_mem defers a flush (PEND) until it drops or the watchdog fires.
// Ports   : clk, rst (sync, active-high); stallreq_if/id/ex/mem stage requests;
//           flush_req + flush_pc redirect request; stall[5:0] per-stage hold vector;
//           flush/new_pc redirect strobe; bus_err watchdog flush marker;
//           stall_cycles saturating stalled-cycle count.
module pipe_stall_ctrl #(
    parameter int unsigned  TIMEOUT_CYCLES = 255,
    parameter logic [31:0]  EXC_VECTOR     = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        bus_err,
    output logic [31:0] stall_cycles
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        bus_err_q, bus_err_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic [5:0]  stall_raw;
    logic        timeout;
    logic        take;
    logic [31:0] target_pc;

    // Deepest requester wins; each deeper stage also holds everything upstream of it.
    always_comb begin
        stall_raw = 6'b000000;
        if (stallreq_mem) begin
            stall_raw = 6'b011111;
        end else if (stallreq_ex) begin
            stall_raw = 6'b001111;
        end else if (stallreq_id) begin
            stall_raw = 6'b000111;
        end else if (stallreq_if) begin
            stall_raw = 6'b000011;
        end
    end

    // During the flush cycle every register must be free to load the bubble.
    assign stall = (state_q == ST_FLUSH) ? 6'b000000 : stall_raw;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((stall != 6'b000000) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Watchdog: counts the current unbroken run of memory wait cycles; the flush
    // cycle itself restarts the count so back-to-back timeouts are spaced evenly.
    always_comb begin
        if (!stallreq_mem || (state_q == ST_FLUSH)) begin
            wd_cnt_d = 16'd0;
        end else begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
    end

    assign timeout = stallreq_mem && (wd_cnt_q == WD_LAST);

    // A flush is wanted if one is requested now or one is already parked in PEND;
    // a fresh request replaces the parked target.
    assign take      = flush_req || (state_q == ST_PEND);
    assign target_pc = flush_req ? flush_pc : pc_q;

    always_comb begin
        state_d   = ST_RUN;
        pc_d      = flush_req ? flush_pc : pc_q;
        new_pc_d  = new_pc_q;
        bus_err_d = 1'b0;
        if (timeout) begin
            // Bus error beats any parked or simultaneous redirect.
            state_d   = ST_FLUSH;
            new_pc_d  = EXC_VECTOR;
            bus_err_d = 1'b1;
        end else if (take && !stallreq_mem) begin
            state_d  = ST_FLUSH;
            new_pc_d = target_pc;
        end else if (take) begin
            state_d = ST_PEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            pc_q           <= 32'h0;
            new_pc_q       <= 32'h0;
            bus_err_q      <= 1'b0;
            wd_cnt_q       <= 16'd0;
            stall_cycles_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            new_pc_q       <= new_pc_d;
            bus_err_q      <= bus_err_d;
            wd_cnt_q       <= wd_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign flush        = (state_q == ST_FLUSH);
    assign new_pc       = new_pc_q;
    assign bus_err      = bus_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    localparam int          T   = 8;
    localparam logic [31:0] EXC = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        bus_err;
    logic [31:0] stall_cycles;

    pipe_stall_ctrl #(.TIMEOUT_CYCLES(T), .EXC_VECTOR(EXC)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .bus_err      (bus_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what the outputs must be in the current cycle, plus the
    // redirect still waiting for memory and the length of the current memory wait.
    bit          m_flush = 1'b0;
    bit          m_be    = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_sc    = 32'h0;
    bit          m_pend  = 1'b0;
    logic [31:0] m_ppc   = 32'h0;
    int          m_run   = 0;

    // Requests {mem,ex,id,if}: the deepest requester d (if=2 .. mem=5) holds the
    // low d stages, i.e. a mask of 2^d - 1.
    function automatic logic [5:0] hold_mask(input bit [3:0] req);
        int d;
        d = req[3] ? 5 : req[2] ? 4 : req[1] ? 3 : req[0] ? 2 : 0;
        return 6'((1 << d) - 1);
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit r, input bit [3:0] req, input bit fr, input logic [31:0] pc);
        logic [5:0] es;
        bit         to, want, nf, nb;
        int         nrun;
        rst          = r;
        stallreq_if  = req[0];
        stallreq_id  = req[1];
        stallreq_ex  = req[2];
        stallreq_mem = req[3];
        flush_req    = fr;
        flush_pc     = pc;
        #1;
        es = m_flush ? 6'b000000 : hold_mask(req);
        chk("stall", 32'(stall), 32'(es));
        chk("flush", 32'(flush), 32'(m_flush));
        chk("bus_err", 32'(bus_err), 32'(m_be));
        chk("stall_cycles", stall_cycles, m_sc);
        if (m_flush) chk("new_pc", new_pc, m_pc);
        if (r) begin
            m_flush = 0; m_be = 0; m_pc = 32'h0; m_sc = 32'h0;
            m_pend = 0; m_ppc = 32'h0; m_run = 0;
        end else begin
            if (es != 6'b000000 && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            to   = req[3] && (m_run == T - 1);
            nrun = (req[3] && !m_flush) ? m_run + 1 : 0;
            want = fr || m_pend;
            nf = 0; nb = 0;
            if (to) begin
                nf = 1; nb = 1; m_pc = EXC; m_pend = 0;
            end else if (want && !req[3]) begin
                nf = 1; m_pc = fr ? pc : m_ppc; m_pend = 0;
            end else if (want) begin
                m_pend = 1; m_ppc = fr ? pc : m_ppc;
            end
            m_flush = nf; m_be = nb; m_run = nrun;
        end
        @(negedge clk);
    endtask

    int          first_cyc, n_fl, n_be;
    int          be_cyc [2];
    logic [31:0] fl_pc;
    int          mem_pct;

    initial begin
        rst = 1'b1;
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        flush_req = 0; flush_pc = 32'h0;
        repeat (2) @(negedge clk);
        step(1, 4'b0000, 0, 0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_stall_cycles", stall_cycles, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);

        // Stall priority and counting.
        step(0, 4'b0110, 0, 0);
        step(0, 4'b1110, 0, 0);
        step(0, 4'b0000, 0, 0);
        chk("prio_stall_cycles", stall_cycles, 32'd2);

        // Plain flush.
        step(0, 4'b0000, 1, 32'h0000_1000);
        chk("plain_flush", 32'(flush), 32'h1);
        chk("plain_new_pc", new_pc, 32'h0000_1000);
        chk("plain_stall", 32'(stall), 32'h0);
        step(0, 4'b0000, 0, 0);
        chk("plain_flush_after", 32'(flush), 32'h0);

        // Deferred flush: memory busy cycles 0-4, requests at 1 and 3.
        first_cyc = -1; n_fl = 0; fl_pc = 32'h0;
        for (int c = 0; c < 9; c++) begin
            step(0, (c < 5) ? 4'b1000 : 4'b0000, (c == 1) || (c == 3),
                 (c == 1) ? 32'h0000_00A0 : 32'h0000_00B0);
            if (flush) begin
                n_fl++;
                if (first_cyc < 0) begin first_cyc = c + 1; fl_pc = new_pc; end
            end
        end
        chk("defer_cycle", 32'(first_cyc), 32'd6);
        chk("defer_pc", fl_pc, 32'h0000_00B0);
        chk("defer_count", 32'(n_fl), 32'd1);

        // Watchdog: memory held busy from cycle 0.
        n_be = 0; be_cyc[0] = -1; be_cyc[1] = -1;
        for (int c = 0; c < 18; c++) begin
            step(0, 4'b1000, 0, 0);
            if (bus_err) begin
                if (n_be < 2) be_cyc[n_be] = c + 1;
                n_be++;
                chk("wd_flush", 32'(flush), 32'h1);
                chk("wd_new_pc", new_pc, EXC);
            end
        end
        chk("wd_first", 32'(be_cyc[0]), 32'(T));
        chk("wd_second", 32'(be_cyc[1]), 32'(2 * T + 1));
        chk("wd_count", 32'(n_be), 32'd2);
        step(0, 4'b0000, 0, 0);

        // Watchdog restart: 7 busy, 1 idle, 7 busy.
        n_be = 0;
        for (int c = 0; c < 16; c++) begin
            step(0, (c == 7 || c == 15) ? 4'b0000 : 4'b1000, 0, 0);
            if (bus_err) n_be++;
        end
        chk("wd_restart_no_err", 32'(n_be), 32'd0);

        // Reset while a redirect is parked.
        step(0, 4'b1000, 1, 32'h0000_0300);
        step(0, 4'b1000, 0, 0);
        step(1, 4'b1000, 0, 0);
        chk("rstpend_stall_cycles", stall_cycles, 32'h0);
        chk("rstpend_stall", 32'(stall), 32'h1F);
        n_fl = 0;
        for (int c = 0; c < 8; c++) begin
            step(0, (c < 5) ? 4'b1000 : 4'b0000, 0, 0);
            if (flush) n_fl++;
        end
        chk("rstpend_no_flush", 32'(n_fl), 32'd0);

        // Randomized traffic with phases of varying memory pressure.
        for (int p = 0; p < 48; p++) begin
            case (p % 4)
                0: mem_pct = 10;
                1: mem_pct = 50;
                2: mem_pct = 90;
                default: mem_pct = 100;
            endcase
            for (int c = 0; c < 48; c++) begin
                step(($urandom_range(0, 399) == 0),
                     {($urandom_range(0, 99) < mem_pct),
                      ($urandom_range(0, 99) < 30),
                      ($urandom_range(0, 99) < 30),
                      ($urandom_range(0, 99) < 30)},
                     ($urandom_range(0, 99) < 12),
                     $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall and flush controller for the five-stage pipeline. It collects stall requests from the IF, ID, EX and MEM stages and drives the per-stage stall vector consumed by the PC register and every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). It also sequences pipeline flushes, deferring them while a memory access is outstanding. A watchdog turns an over-long memory wait into a bus-error flush. A saturating counter accumulates stall cycles for performance monitoring.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: consecutive stallreq_mem cycles that trigger a bus error (1..65535).
- EXC_VECTOR, 32'h0000_0020: PC loaded on a bus-error flush.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- stallreq_if  input  1  IF requests a stall (instruction fetch wait).
- stallreq_id  input  1  ID requests a stall (load-use hazard).
- stallreq_ex  input  1  EX requests a stall (multi-cycle operation).
- stallreq_mem  input  1  MEM requests a stall (data bus wait).
- flush_req  input  1  single-cycle request to flush the pipeline and redirect the PC.
- flush_pc  input  32  redirect target, sampled with flush_req.
- stall  output  6  bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB, 5 = WB; 1 = hold.
- flush  output  1  clears all inter-stage registers this cycle.
- new_pc  output  32  PC to load while flush = 1.
- bus_err  output  1  one-cycle pulse marking a watchdog-initiated flush.
- stall_cycles  output  32  count of cycles with stall != 0; saturates at 32'hFFFF_FFFF.

## Operation
- The stall vector is combinational from the requests. The deepest requester wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- In the FLUSH state, stall is forced to 6'b000000.
- States:
  - RUN: normal operation.
  - PEND: a flush is accepted but a memory access is still outstanding.
  - FLUSH: one cycle; flush = 1 and new_pc is valid.
- RUN transitions:
  - flush_req && !stallreq_mem → FLUSH, capturing flush_pc.
  - flush_req && stallreq_mem → PEND, capturing flush_pc.
- PEND transitions:
  - Stays in PEND while stallreq_mem is high.
  - Goes to FLUSH on the first cycle stallreq_mem is low.
  - A further flush_req in PEND overwrites the captured PC; the newest request wins.
- FLUSH always returns to RUN after one cycle. A flush_req arriving during FLUSH is treated as arriving in RUN: the next cycle is FLUSH again with the new PC.
- Watchdog:
  - A 16-bit counter increments on every cycle stallreq_mem is high.
  - It clears on every cycle stallreq_mem is low, and on any FLUSH.
  - When the counter reaches TIMEOUT_CYCLES - 1 with stallreq_mem still high, the next state is FLUSH with PC EXC_VECTOR, and bus_err pulses in that FLUSH cycle.
  - The bus error overrides any pending or simultaneous flush_req.
- stall_cycles increments by 1 on every non-reset cycle with stall != 0 and saturates at its maximum value.
- Reset values: state RUN, flush 0, new_pc 32'h0, bus_err 0, watchdog counter 0, stall_cycles 0, captured PC 0.
- With all request inputs low, stall is 0 during and after reset.
- Reset mid-PEND or mid-FLUSH discards the pending redirect.

## Timing
- stall responds to the stallreq_* inputs in the same cycle, with zero latency.
- flush, new_pc and bus_err are registered outputs.
- Flush latency:
  - flush_req sampled at edge N with stallreq_mem low gives flush = 1 in cycle N+1, for exactly one cycle.
  - If stallreq_mem stays high through cycle N+k, flush occurs in cycle N+k+1 at the earliest.
- Watchdog: stallreq_mem high continuously from cycle 0 produces FLUSH and bus_err in cycle TIMEOUT_CYCLES.
- stall_cycles reflects a stalled cycle one edge after that cycle.

## Test plan
- Stall priority: assert stallreq_id and stallreq_ex together → stall = 6'b001111. Add stallreq_mem → 6'b011111. Release all → 6'b000000. stall_cycles = 2 after those two stalled cycles.
- Plain flush: flush_req = 1, flush_pc = 32'h0000_1000 for one cycle with no stalls → next cycle flush = 1, new_pc = 32'h1000, stall = 0. The following cycle flush = 0.
- Deferred flush: stallreq_mem high for cycles 0–4, flush_req with PC 32'hA0 at cycle 1 and PC 32'hB0 at cycle 3 → flush = 1 only in cycle 6, with new_pc = 32'hB0.
- Watchdog: TIMEOUT_CYCLES = 8, stallreq_mem held high → flush = 1, bus_err = 1, new_pc = 32'h20 in cycle 8. Both are 0 in cycle 9. The counter restarts, so a second timeout fires at cycle 17 if stallreq_mem stays high.
- Watchdog reset: stallreq_mem high for 7 cycles, low for 1, high for 7 (TIMEOUT_CYCLES = 8) → no bus_err.
- Reset mid-PEND: enter PEND, then assert rst for 1 cycle while stallreq_mem stays high → no flush ever, stall_cycles = 0 after reset, stall = 6'b011111.
